// File: rtl/cgp_fitness_eval_if.sv
// rtl/cgp_fitness_eval_if.sv - control, result and candidate-netlist signals of the CGP fitness evaluator
//
// start/abort        : evaluation request / cancel (toward evaluator)
// busy/done          : evaluation in progress / one-cycle results-valid pulse
// mismatches/score   : registered results of the last completed sweep
// cand_in/cand_out   : pattern driven into the candidate netlist / its response
// slave modport is the evaluator's view; master is the controller plus candidate.
interface cgp_fitness_eval_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
);
    localparam int CW = $clog2((1 << N_IN) * N_OUT + 1);

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [CW-1:0]     mismatches;
    logic [CW-1:0]     score;
    logic [N_IN-1:0]   cand_in;
    logic [N_OUT-1:0]  cand_out;

    modport master (
        output start, abort, cand_out,
        input  busy, done, mismatches, score, cand_in
    );

    modport slave (
        input  start, abort, cand_out,
        output busy, done, mismatches, score, cand_in
    );
endinterface

// File: rtl/cgp_fitness_eval.sv
// rtl/cgp_fitness_eval.sv - sweeps all input patterns through a CGP candidate and scores it against odd parity
//
// clk    : rising-edge clock
// rst_n  : asynchronous active-low reset
// bus    : cgp_fitness_eval_if.slave (start/abort in, busy/done/mismatches/score out,
//          cand_in driven to the candidate, cand_out sampled from it)
module cgp_fitness_eval #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cgp_fitness_eval_if.slave  bus
);
    localparam int PAT = 1 << N_IN;
    localparam int TOT = PAT * N_OUT;
    localparam int CW  = $clog2(TOT + 1);
    localparam int SW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [N_IN-1:0]  pat, pat_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [CW-1:0]    acc, acc_nxt;
    logic [CW-1:0]    mism, mism_nxt;
    logic [CW-1:0]    score, score_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;

    logic             golden;
    logic [CW-1:0]    miss_cnt;
    logic [CW-1:0]    total;
    logic [CW-1:0]    raw_score;

    // Per-pattern miss count; !== makes an undriven/X candidate bit a miss.
    always_comb begin
        golden   = ^pat;
        miss_cnt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (bus.cand_out[i] !== golden) begin
                miss_cnt = miss_cnt + CW'(1);
            end
        end
        total     = acc + miss_cnt;
        raw_score = CW'(TOT) - total;
    end

    always_comb begin
        state_nxt  = state;
        pat_nxt    = pat;
        settle_nxt = settle_cnt;
        acc_nxt    = acc;
        mism_nxt   = mism;
        score_nxt  = score;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = RUN;
                    pat_nxt    = '0;
                    settle_nxt = '0;
                    acc_nxt    = '0;
                    busy_nxt   = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt  = IDLE;
                    pat_nxt    = '0;
                    settle_nxt = '0;
                    busy_nxt   = 1'b0;
                end else if (settle_cnt == SW'(SETTLE)) begin
                    settle_nxt = '0;
                    if (pat != N_IN'(PAT - 1)) begin
                        pat_nxt = pat + N_IN'(1);
                        acc_nxt = total;
                    end else begin
                        // Last pattern stays on cand_in; results publish with done.
                        state_nxt = DONE;
                        acc_nxt   = total;
                        mism_nxt  = total;
                        // A score of exactly half is what a constant/degenerate
                        // candidate earns on parity, so it is suppressed to 0.
                        score_nxt = (raw_score == CW'(TOT / 2)) ? '0 : raw_score;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pat        <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            mism       <= '0;
            score      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pat        <= pat_nxt;
            settle_cnt <= settle_nxt;
            acc        <= acc_nxt;
            mism       <= mism_nxt;
            score      <= score_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    assign bus.cand_in    = pat;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.mismatches = mism;
    assign bus.score      = score;
endmodule

// File: tb/tb_cgp_fitness_eval.sv
// tb/tb_cgp_fitness_eval.sv - randomized self-checking bench for cgp_fitness_eval against a behavioural model
module tb_cgp_fitness_eval;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 1;
    localparam int SETTLE = 1;
    localparam int PAT    = 16;
    localparam int TOT    = 16;
    localparam int HOLD   = SETTLE + 1;
    localparam int LAT    = PAT * HOLD;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cgp_fitness_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    cgp_fitness_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Candidate netlist: a truth table, with optional X on selected patterns.
    logic [15:0] tt;
    logic [15:0] xmask;

    function automatic logic cand_val(input logic [15:0] t, input logic [15:0] xm, input int p);
        return xm[p] ? 1'bx : t[p];
    endfunction

    assign bus.cand_out[0] = cand_val(tt, xmask, int'(bus.cand_in));

    function automatic int model_mis(input logic [15:0] t, input logic [15:0] xm);
        int m;
        m = 0;
        for (int p = 0; p < PAT; p++) begin
            logic v;
            logic g;
            v = cand_val(t, xm, p);
            g = (($countones(p) % 2) == 1);
            if (v !== g) m++;
        end
        return m;
    endfunction

    function automatic int model_score(input int m);
        return ((TOT - m) == TOT / 2) ? 0 : TOT - m;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int run_s     = -1;
    int run_mis   = 0;
    int run_score = 0;
    int res_mis   = 0;
    int res_score = 0;
    int n_tests   = 0;
    int n_fail    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison of all outputs against the model timeline.
    initial begin : cmp
        int e;
        logic eb, ed;
        int ec, em, es;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                e = (run_s >= 0) ? cyc - run_s : -1;
                if (e >= 0 && e < LAT) begin
                    eb = 1'b1; ed = 1'b0; ec = e / HOLD; em = res_mis; es = res_score;
                end else if (e == LAT) begin
                    eb = 1'b0; ed = 1'b1; ec = PAT - 1; em = run_mis; es = run_score;
                end else if (e > LAT) begin
                    eb = 1'b0; ed = 1'b0; ec = PAT - 1; em = res_mis; es = res_score;
                end else begin
                    eb = 1'b0; ed = 1'b0; ec = 0; em = res_mis; es = res_score;
                end
                chk("busy", bus.busy, eb);
                chk("done", bus.done, ed);
                chk("cand_in", bus.cand_in, ec);
                chk("mismatches", bus.mismatches, em);
                chk("score", bus.score, es);
                if (e == LAT) begin
                    res_mis   = run_mis;
                    res_score = run_score;
                end
            end
        end
    end

    // Called just after a negedge; consumes one posedge.
    task automatic pulse_start(input bit with_abort);
        bit idle;
        idle = (run_s < 0) || (cyc - run_s > LAT);
        bus.start = 1'b1;
        bus.abort = with_abort;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (idle) begin
            run_s     = cyc;
            run_mis   = model_mis(tt, xmask);
            run_score = model_score(run_mis);
        end
    endtask

    task automatic abort_now();
        bit running;
        running = (run_s >= 0) && (cyc - run_s < LAT);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        if (running) run_s = -1;
    endtask

    task automatic run_eval(input string nm, input logic [15:0] t, input logic [15:0] xm,
                            input int em, input int es, input bit with_abort, input bit poke);
        bit got;
        @(negedge clk);
        tt    = t;
        xmask = xm;
        pulse_start(with_abort);
        got = 1'b0;
        for (int k = 0; k < LAT + 8 && !got; k++) begin
            @(negedge clk);
            bus.start = (poke && k == 10);
            if (bus.done === 1'b1) got = 1'b1;
        end
        bus.start = 1'b0;
        if (!got) begin
            chk({nm, " done_seen"}, 0, 1);
        end else begin
            chk({nm, " latency"}, cyc - run_s, LAT);
            if (em >= 0) begin
                chk({nm, " mismatches_lit"}, bus.mismatches, em);
                chk({nm, " score_lit"}, bus.score, es);
            end
            if (poke) begin
                bus.start = 1'b1;   // lands on the DONE cycle
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tt        = 16'h6996;
        xmask     = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst cand_in", bus.cand_in, 0);
        chk("rst mismatches", bus.mismatches, 0);
        chk("rst score", bus.score, 0);
        rst_n = 1'b1;

        run_eval("xor", 16'h6996, 16'h0000, 0, 16, 1'b0, 1'b0);
        run_eval("xor_inv15", 16'hE996, 16'h0000, 1, 15, 1'b0, 1'b0);
        run_eval("const0", 16'h0000, 16'h0000, 8, 0, 1'b0, 1'b0);
        run_eval("xnor", 16'h9669, 16'h0000, 16, 0, 1'b0, 1'b0);
        run_eval("xor_again", 16'h6996, 16'h0000, 0, 16, 1'b0, 1'b0);

        // Abort on pattern 7: previous results retained, no done.
        @(negedge clk);
        tt = 16'h9669;
        pulse_start(1'b0);
        repeat (15) @(negedge clk);
        abort_now();
        repeat (4) @(negedge clk);
        chk("abort mismatches_lit", bus.mismatches, 0);
        chk("abort score_lit", bus.score, 16);

        // Abort while idle is ignored.
        abort_now();
        @(negedge clk);

        // Reset on pattern 7.
        pulse_start(1'b0);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", bus.busy, 0);
        chk("midrst cand_in", bus.cand_in, 0);
        chk("midrst score", bus.score, 0);
        run_s = -1; res_mis = 0; res_score = 0;
        repeat (2) @(negedge clk);
        chk("midrst done", bus.done, 0);
        rst_n = 1'b1;

        // Extra start mid-run and on the DONE cycle, plus an X candidate bit.
        run_eval("poke_x", 16'h6996, 16'h0002, -1, -1, 1'b0, 1'b1);
        // start and abort together in IDLE: start wins.
        run_eval("start_wins", 16'h6996, 16'h0000, 0, 16, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if (i % 3 == 2) begin
                @(negedge clk);
                tt    = r;
                xmask = 16'h0000;
                pulse_start(1'b0);
                repeat ($urandom_range(1, 32)) @(negedge clk);
                abort_now();
                repeat (2) @(negedge clk);
            end else begin
                run_eval("random", r, 16'h0000, -1, -1, 1'b0, (i % 4) == 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
